// File: rtl/fractal_tile_scheduler.sv
// Frame sequencer: deals pixel jobs round-robin to escape-time workers and writes their results to VRAM.
// Optional frame cycle counter is enabled by defining SCHED_PERF_CNT_EN.
module fractal_tile_scheduler #(
  parameter int NUM_WORKERS = 4,
  parameter int IMG_W       = 256,
  parameter int IMG_H       = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     frame_done,
  output logic [NUM_WORKERS-1:0]   job_valid,
  input  logic [NUM_WORKERS-1:0]   job_ready,
  output logic [8:0]               job_x,
  output logic [8:0]               job_y,
  input  logic [NUM_WORKERS-1:0]   res_valid,
  output logic [NUM_WORKERS-1:0]   res_ready,
  input  logic [8*NUM_WORKERS-1:0] res_data,
  output logic                     wr_en,
  output logic [17:0]              wr_addr,
  output logic [7:0]               wr_data
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0]              frame_cycles
`endif
);

  localparam int IW = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;
  localparam logic [8:0] X_LAST = 9'(IMG_W - 1);
  localparam logic [8:0] Y_LAST = 9'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

  // Round-robin search: lowest set bit above 'last', otherwise lowest set bit at or below it.
  function automatic logic [IW:0] rr_pick(input logic [NUM_WORKERS-1:0] mask,
                                          input logic [IW-1:0] last);
    logic [IW:0] r;
    r = '0;
    for (int i = NUM_WORKERS - 1; i >= 0; i--)
      if (mask[i] && (i <= int'(last))) r = {1'b1, IW'(i)};
    for (int i = NUM_WORKERS - 1; i >= 0; i--)
      if (mask[i] && (i > int'(last))) r = {1'b1, IW'(i)};
    return r;
  endfunction

  state_t                 state, state_next;
  logic [8:0]             px, py;
  logic [NUM_WORKERS-1:0] wbusy;
  logic [17:0]            waddr [NUM_WORKERS];
  logic                   offer_vld;
  logic [IW-1:0]          offer_idx, job_ptr, res_ptr;

  logic                   accept, last_pix;
  logic [NUM_WORKERS-1:0] res_req, idle_mask;
  logic                   gnt_vld, pick_vld;
  logic [IW-1:0]          gnt_idx, pick_idx;
  logic [7:0]             gnt_data;
  logic [17:0]            gnt_addr, pix_addr;

  assign job_x    = px;
  assign job_y    = py;
  assign pix_addr = {py[8:6], px[8:6], py[5:0], px[5:0]};
  assign last_pix = (px == X_LAST) && (py == Y_LAST);
  assign res_req  = res_valid & wbusy;

  always_comb begin
    accept    = 1'b0;
    job_valid = '0;
    res_ready = '0;
    gnt_data  = '0;
    gnt_addr  = '0;
    idle_mask = ~wbusy;
    {gnt_vld, gnt_idx} = rr_pick(res_req, res_ptr);
    for (int i = 0; i < NUM_WORKERS; i++) begin
      if (offer_vld && (offer_idx == IW'(i))) begin
        job_valid[i] = 1'b1;
        accept       = job_ready[i];
      end
      if (gnt_vld && (gnt_idx == IW'(i))) begin
        res_ready[i] = 1'b1;
        gnt_data     = res_data[8*i +: 8];
        gnt_addr     = waddr[i];
      end
    end
    // A worker taking a job this cycle is not a candidate for the next offer.
    for (int i = 0; i < NUM_WORKERS; i++)
      if (accept && (offer_idx == IW'(i))) idle_mask[i] = 1'b0;
    {pick_vld, pick_idx} = rr_pick(idle_mask, accept ? offer_idx : job_ptr);
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    frame_done = (state == DONE);
    case (state)
      IDLE:     if (start) state_next = DISPATCH;
      DISPATCH: if (accept && last_pix) state_next = DRAIN;
      DRAIN:    if ((wbusy == '0) && !wr_en) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      px        <= '0;
      py        <= '0;
      wbusy     <= '0;
      offer_vld <= 1'b0;
      offer_idx <= '0;
      job_ptr   <= IW'(NUM_WORKERS - 1);
      res_ptr   <= IW'(NUM_WORKERS - 1);
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      state <= state_next;

      if ((state == IDLE) && start) begin
        px <= '0;
        py <= '0;
      end else if (accept) begin
        if (px == X_LAST) begin
          px <= '0;
          py <= (py == Y_LAST) ? 9'd0 : py + 9'd1;
        end else begin
          px <= px + 9'd1;
        end
      end

      // The offer is registered so it cannot move while a worker stalls on job_ready.
      if (state_next == DISPATCH) begin
        if (!offer_vld || accept) begin
          offer_vld <= pick_vld;
          offer_idx <= pick_idx;
        end
      end else begin
        offer_vld <= 1'b0;
      end
      if (accept) job_ptr <= offer_idx;

      for (int i = 0; i < NUM_WORKERS; i++) begin
        if (gnt_vld && (gnt_idx == IW'(i)))        wbusy[i] <= 1'b0;
        else if (accept && (offer_idx == IW'(i)))  wbusy[i] <= 1'b1;
      end

      wr_en <= gnt_vld;
      if (gnt_vld) begin
        res_ptr <= gnt_idx;
        wr_addr <= gnt_addr;
        wr_data <= gnt_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_WORKERS; i++)
      if (accept && (offer_idx == IW'(i))) waddr[i] <= pix_addr;
  end

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] cyc_cnt, cyc_inc;

  assign cyc_inc = (cyc_cnt == 32'hFFFF_FFFF) ? cyc_cnt : cyc_cnt + 32'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt      <= '0;
      frame_cycles <= '0;
    end else begin
      if ((state == IDLE) && start)
        cyc_cnt <= '0;
      else if ((state == DISPATCH) || (state == DRAIN))
        cyc_cnt <= cyc_inc;
      // Include the final DRAIN cycle in the snapshot.
      if ((state == DRAIN) && (state_next == DONE))
        frame_cycles <= cyc_inc;
    end
  end
`endif

endmodule

// File: tb/tb_fractal_tile_scheduler.sv
// Randomized bench for fractal_tile_scheduler: worker models, round-robin grant model and a per-pixel scoreboard.
module tb_fractal_tile_scheduler;
  localparam int NW   = 4;
  localparam int W    = 128;
  localparam int H    = 4;
  localparam int NPIX = W * H;

  logic            clk = 1'b0;
  logic            reset, start;
  logic            busy, frame_done;
  logic [NW-1:0]   job_valid, job_ready, res_valid, res_ready;
  logic [8:0]      job_x, job_y;
  logic [8*NW-1:0] res_data;
  logic            wr_en;
  logic [17:0]     wr_addr;
  logic [7:0]      wr_data;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0]     frame_cycles;
`endif

  fractal_tile_scheduler #(.NUM_WORKERS(NW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .frame_done(frame_done),
    .job_valid(job_valid), .job_ready(job_ready), .job_x(job_x), .job_y(job_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef SCHED_PERF_CNT_EN
    , .frame_cycles(frame_cycles)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Worker and scoreboard model
  logic [NW-1:0] mbusy;
  int mx [NW], my [NW], mdly [NW], stall [NW];
  int ex, ey, jobs, salt, mode, last_gnt, oob;
  int wr_cnt [NPIX];
  bit exp_wr, prev_valid;
  int exp_addr, exp_data;
  logic [NW-1:0] prev_jv;
  logic [8:0] prev_x, prev_y;

  function automatic int pix_data(input int x, input int y);
    return (x * 37 + y * 101 + salt) & 255;
  endfunction

  function automatic int addr_of(input int x, input int y);
    return ((y >> 6) << 15) | ((x >> 6) << 12) | ((y & 63) << 6) | (x & 63);
  endfunction

  function automatic int idx_of(input logic [NW-1:0] v);
    int r = 0;
    for (int i = 0; i < NW; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    mbusy = '0; exp_wr = 0; prev_valid = 0; last_gnt = -1;
    for (int i = 0; i < NW; i++) begin stall[i] = 0; mdly[i] = 0; end
  endtask

  task automatic step();
    logic [NW-1:0] req, exp_rr, acc, gnt;
    int a, g, x, y, wa;
    @(negedge clk);
    for (int i = 0; i < NW; i++) begin
      if (!mbusy[i] && job_valid[i] && stall[i] > 0) begin
        job_ready[i] = 1'b0; stall[i]--;
      end else begin
        job_ready[i] = !mbusy[i];
      end
      if (mbusy[i] && mdly[i] == 0) begin
        res_valid[i] = 1'b1; res_data[8*i +: 8] = 8'(pix_data(mx[i], my[i]));
      end else if (!mbusy[i] && (mode == 1 || $urandom_range(0, 7) == 0)) begin
        res_valid[i] = 1'b1; res_data[8*i +: 8] = 8'($urandom);
      end else begin
        res_valid[i] = 1'b0; res_data[8*i +: 8] = 8'($urandom);
      end
    end
    #1;
    if (reset) begin model_reset(); return; end

    req = res_valid & mbusy;
    exp_rr = '0;
    if (last_gnt < 0) begin
      chk("res_ready_legal", ((res_ready & ~req) == 0) && $onehot0(res_ready) &&
                             ((req == 0) || (res_ready != 0)), 1);
    end else begin
      for (int k = NW; k >= 1; k--)
        if (req[(last_gnt + k) % NW]) exp_rr = NW'(1) << ((last_gnt + k) % NW);
      chk("res_ready_rr", res_ready, exp_rr);
    end

    chk("wr_en", wr_en, exp_wr);
    if (exp_wr) begin
      chk("wr_addr", wr_addr, exp_addr);
      chk("wr_data", wr_data, exp_data);
    end
    if (wr_en) begin
      wa = int'(wr_addr);
      x = (((wa >> 12) & 7) << 6) | (wa & 63);
      y = (((wa >> 15) & 7) << 6) | ((wa >> 6) & 63);
      if (x < W && y < H) wr_cnt[y * W + x]++;
      else oob++;
      if (exp_wr && exp_addr == addr_of(3, 2)) chk("addr_3_2", wr_addr, 18'h00083);
    end

    chk("jv_onehot", $onehot0(job_valid), 1);
    if (prev_valid) begin
      chk("jv_hold", job_valid, prev_jv);
      chk("jx_hold", job_x, prev_x);
      chk("jy_hold", job_y, prev_y);
    end
    if (job_valid != 0) begin
      a = idx_of(job_valid);
      chk("offer_idle", mbusy[a], 0);
      chk("job_x", job_x, ex);
      chk("job_y", job_y, ey);
    end

    acc = job_valid & job_ready;
    gnt = res_valid & res_ready;
    for (int i = 0; i < NW; i++) if (mbusy[i] && mdly[i] > 0) mdly[i]--;
    exp_wr = 0;
    if (gnt != 0) begin
      g = idx_of(gnt);
      if (mbusy[g]) begin
        exp_wr = 1;
        exp_addr = addr_of(mx[g], my[g]);
        exp_data = pix_data(mx[g], my[g]);
        mbusy[g] = 1'b0;
        stall[g] = ($urandom_range(0, 3) == 0) ? 5 : 0;
        last_gnt = g;
      end
    end
    if (acc != 0) begin
      a = idx_of(acc);
      mbusy[a] = 1'b1; mx[a] = ex; my[a] = ey;
      mdly[a] = (mode == 1) ? 0 : $urandom_range(0, 8);
      jobs++; ex++;
      if (ex == W) begin ex = 0; ey++; end
    end
    prev_valid = (job_valid != 0) && (acc == 0);
    prev_jv = job_valid; prev_x = job_x; prev_y = job_y;
  endtask

  task automatic check_reset_vals();
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_job_valid", job_valid, 0);
    chk("rst_res_ready", res_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_job_x", job_x, 0);
    chk("rst_job_y", job_y, 0);
`ifdef SCHED_PERF_CNT_EN
    chk("rst_frame_cycles", frame_cycles, 0);
`endif
  endtask

  task automatic run_frame(input int md, input int rst_at);
    int n, nbad;
    bit done;
    mode = md; salt = $urandom_range(0, 255);
    ex = 0; ey = 0; jobs = 0; oob = 0;
    for (int i = 0; i < NPIX; i++) wr_cnt[i] = 0;
    start = 1'b1; step(); start = 1'b0;
    step();
    chk("first_jv", job_valid != 0, 1);
    n = 1; done = 0;
    while (!done && n < 20000) begin
      if (rst_at >= 0 && jobs == rst_at) begin
        reset = 1'b1; step(); reset = 1'b0;
        step();
        check_reset_vals();
        return;
      end
      if ($urandom_range(0, 15) == 0) start = 1'b1;
      step(); start = 1'b0; n++;
      if (frame_done) done = 1;
    end
    chk("frame_timeout", done, 1);
    if (done) begin
      chk("wr_at_done", wr_en, 0);
      chk("jobs", jobs, NPIX);
      nbad = oob;
      for (int i = 0; i < NPIX; i++) if (wr_cnt[i] != 1) nbad++;
      chk("pix_once", nbad, 0);
`ifdef SCHED_PERF_CNT_EN
      chk("frame_cycles", frame_cycles, n);
`endif
      step();
      chk("done_pulse", frame_done, 0);
      chk("idle_after", busy, 0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    job_ready = '0; res_valid = '0; res_data = '0;
    mode = 0; salt = 0;
    model_reset();
    step(); step();
    reset = 1'b0;
    step();
    check_reset_vals();
    run_frame(0, -1);
    run_frame(0, 7);
    run_frame(0, -1);
    run_frame(1, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fractal_tile_scheduler.md
# fractal_tile_scheduler

Sequences one full fractal frame by handing pixel coordinates to NUM_WORKERS escape-time compute engines. Collects their 8-bit escape counts and writes them into VRAM through a single write port, using the same 18-bit block-mapped address layout the VGA scan-out reads. Sits between the host start/done control and the worker array, and owns the write side of VRAM.

## Interface
Parameters:
- NUM_WORKERS, 4, number of compute engines (1..8)
- IMG_W, 256, frame width in pixels (power of two, 2..256)
- IMG_H, 256, frame height in pixels (power of two, 2..256)

Ports:
- clk  in  1  system/pixel clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame when idle
- busy  out  1  high from accepted start until frame_done inclusive
- frame_done  out  1  one-cycle pulse when the frame is fully written
- job_valid  out  NUM_WORKERS  one-hot job offer
- job_ready  in  NUM_WORKERS  worker accepts job
- job_x  out  9  pixel column of offered job
- job_y  out  9  pixel row of offered job
- res_valid  in  NUM_WORKERS  worker has a result
- res_ready  out  NUM_WORKERS  one-hot result grant
- res_data  in  8*NUM_WORKERS  packed escape counts; worker i at [8i+7:8i]
- wr_en  out  1  VRAM write strobe
- wr_addr  out  18  VRAM write address
- wr_data  out  8  escape count to write
- frame_cycles  out  32  cycles of the last frame (only when SCHED_PERF_CNT_EN is defined)

## Operation
- Address map: addr = {y[8:6], x[8:6], y[5:0], x[5:0]}, with x and y zero-extended to 9 bits.
- FSM states: IDLE, DISPATCH, DRAIN, DONE.
  - IDLE -> DISPATCH on start. Pixel counters are set to (0,0).
  - DISPATCH -> DRAIN when the job for (IMG_W-1, IMG_H-1) is accepted.
  - DRAIN -> DONE when every worker is idle and no write is pending.
  - DONE -> IDLE unconditionally after one cycle.
- start is ignored outside IDLE.
- Raster order: x increments first. x wraps from IMG_W-1 to 0 with y+1. Each pixel is dispatched exactly once.
- Per-worker state: a busy bit plus an 18-bit pending address. Each worker holds at most one outstanding job.
- Dispatch:
  - In DISPATCH, a round-robin pointer selects the next idle worker, starting after the last worker that accepted. job_valid is asserted for that worker only.
  - job_valid does not depend on job_ready. Once asserted, the offer (index, job_x, job_y) is held stable until accepted.
  - On acceptance, the worker's busy bit is set and its address is latched, and the pointer and pixel counters advance.
  - If no worker is idle, job_valid = 0.
- Results:
  - A round-robin arbiter grants one res_valid per cycle via res_ready, starting after the last granted worker.
  - On the handshake, the worker's busy bit clears. That worker is eligible for a new offer from the next cycle, never the same cycle.
- A worker may have its result granted and another worker may accept a job in the same cycle; both complete.
- res_valid from a non-busy worker is never granted. It is ignored.

## Timing
- Reset values: busy=0, frame_done=0, job_valid=0, res_ready=0, wr_en=0, wr_addr=0, wr_data=0, job_x=0, job_y=0, frame_cycles=0.
- Reset mid-frame: all state returns to IDLE, all busy bits are cleared, and in-flight results are discarded. No write occurs in the cycle after reset.
- Write latency: wr_en, wr_addr and wr_data are registered. They are valid exactly 1 cycle after the result handshake, for 1 cycle.
- The write port sustains 1 write per cycle. Results never stall on VRAM.
- First job_valid is asserted the cycle after start is sampled.
- frame_done is asserted in DONE, at least 1 cycle after the final wr_en.
- Throughput: up to one dispatch and one write per cycle.

## Configuration
- SCHED_PERF_CNT_EN defined:
  - A 32-bit counter clears on accepted start and increments every cycle in DISPATCH and DRAIN.
  - On entering DONE, the count is copied to frame_cycles, which holds until the next DONE or reset.
  - The counter saturates at 2^32-1.
- SCHED_PERF_CNT_EN undefined: the frame_cycles port and the counter are absent.

## Test plan
- IMG_W=IMG_H=4, NUM_WORKERS=1, worker always ready with a 3-cycle result delay. After start, expect 16 jobs in order (0,0),(1,0)..(3,3), 16 writes with wr_data equal to the worker's output, and wr_addr for (3,2) = 18'h00083. frame_done fires once.
- NUM_WORKERS=4, all res_valid held high continuously. Expect res_ready grants rotating 0,1,2,3,0 and one write per cycle.
- Workers return results out of order with random delays. Every pixel address is written exactly once and carries that pixel's data, checked by a scoreboard over the 16 or 65536 pixels.
- job_ready held low for 5 cycles on the offered worker. job_valid, job_x and job_y stay stable for all 5 cycles, and no other worker is offered.
- Assert reset in DISPATCH after 7 jobs. The next cycle shows all outputs at reset values. A new start restarts the frame at (0,0).
- With SCHED_PERF_CNT_EN defined, 1 worker, 4x4 frame, fixed 2-cycle latency: frame_cycles equals the observed start-to-DONE cycle count, and start during busy is ignored.
